// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-item vending controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  localparam logic [2:0] VAL_1 = 3'd1;
  localparam logic [2:0] VAL_2 = 3'd2;
  localparam logic [2:0] VAL_5 = 3'd5;

  // Unit value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [2:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_1:  return VAL_1;
      COIN_2:  return VAL_2;
      COIN_5:  return VAL_5;
      default: return 3'd0;
    endcase
  endfunction

  // Pull price field idx (w bits wide) out of a packed price vector.
  // Out-of-range indices shift everything away and read as 0.
  function automatic logic [31:0] price_of(input logic [63:0] prices,
                                           input int idx, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 32'((prices >> (idx * w)) & mask);
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with decrement-on-vend, restock load and sold-out flags.
// Latency: counters update on the clock edge; sold_out follows the counters combinationally.
// Backpressure: none; a decrement of an empty counter is ignored, load beats decrement.
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 5,
  parameter int STOCK_MAX  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec,
  input  logic [SEL_W-1:0]     dec_id,
  input  logic                 load,
  input  logic [SEL_W-1:0]     load_id,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  // Stock counters: restock of an item takes priority over a vend of the same item.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (load && (load_id == SEL_W'(i)))
          stock[i] <= STOCK_W'(STOCK_MAX);
        else if (dec && (dec_id == SEL_W'(i)) && (stock[i] != '0))
          stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

  // Sold-out flags straight from the counters.
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock[i] == '0);
  end

endmodule

// File: rtl/vending_fsm_multi.sv
// Multi-item vending controller: coin credit, priced vend, unit-per-cycle change/refund, stock.
// Latency: accepted selection -> product pulse 1 cycle; change pulses follow on consecutive cycles.
// Backpressure: none; overflowing or busy-time coins get a coin_reject pulse, unservable selections are dropped.
module vending_fsm_multi
  import vending_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 15,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = 16'h6423,
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 5,
  parameter int STOCK_MAX  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coin,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 sel_valid,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 product,
  output logic [SEL_W-1:0]     product_id,
  output logic                 change,
  output logic                 coin_reject,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 busy
);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   sum;
  logic [SEL_W-1:0]    id_n;
  logic                coin_in, coin_fits, sel_ok, can_buy;
  logic                reject_n, vend_n, dec, stock_load;

  // Sum is one bit wider than credit so an overflowing coin is visible before truncation.
  assign coin_in    = (coin != COIN_NONE);
  assign sum        = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin));
  assign coin_fits  = (sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_ok     = (int'(sel) < NUM_ITEMS);
  assign price      = CREDIT_W'(price_of(64'(PRICES), int'(sel), CREDIT_W));
  assign can_buy    = sel_valid && sel_ok && !sold_out[sel] && (credit >= price);
  assign stock_load = restock && sel_ok;

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT),
    .STOCK_MAX (STOCK_MAX)
  ) u_stock (
    .clk     (clk),
    .rst     (rst),
    .dec     (dec),
    .dec_id  (product_id),
    .load    (stock_load),
    .load_id (sel),
    .sold_out(sold_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state, next credit and next values of the registered pulses.
  always_comb begin
    state_n  = state;
    credit_n = credit;
    id_n     = product_id;
    reject_n = 1'b0;
    vend_n   = 1'b0;
    dec      = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if ((state == COLLECT) && cancel) begin
          // Full refund; a coin arriving alongside the cancel is handed back.
          state_n  = CHANGE;
          reject_n = coin_in;
        end else if (coin_in) begin
          // A coin always outranks a selection in the same cycle.
          if (coin_fits) begin
            credit_n = sum[CREDIT_W-1:0];
            state_n  = COLLECT;
          end else begin
            reject_n = 1'b1;
          end
        end else if ((state == COLLECT) && can_buy) begin
          credit_n = credit - price;
          id_n     = sel;
          vend_n   = 1'b1;
          state_n  = VEND;
        end
      end
      VEND: begin
        dec      = 1'b1;
        reject_n = coin_in;
        state_n  = (credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_n = coin_in;
        if (credit != '0) credit_n = credit - CREDIT_W'(1);
        if (credit <= CREDIT_W'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output and credit registers; change/busy are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit      <= '0;
      product     <= 1'b0;
      product_id  <= '0;
      change      <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      credit      <= credit_n;
      product     <= vend_n;
      product_id  <= id_n;
      change      <= (state_n == CHANGE);
      coin_reject <= reject_n;
      busy        <= (state_n == VEND) || (state_n == CHANGE);
    end
  end

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Scoreboard bench for vending_fsm_multi: directed stimulus pushes expected
// product/reject/change events; a negedge monitor pops and compares them.
module tb_vending_fsm_multi;
  import vending_pkg::*;

  logic       clk, rst;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       sel_valid, cancel, restock;
  logic       product, change, coin_reject, busy;
  logic [1:0] product_id;
  logic [3:0] credit;
  logic [3:0] sold_out;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  localparam int EV_PROD = 16;  // + item id
  localparam int EV_REJ  = 32;
  localparam int EV_CHG  = 48;

  vending_fsm_multi dut (
    .clk        (clk),
    .rst        (rst),
    .coin       (coin),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .cancel     (cancel),
    .restock    (restock),
    .product    (product),
    .product_id (product_id),
    .change     (change),
    .coin_reject(coin_reject),
    .credit     (credit),
    .sold_out   (sold_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input int got);
    int e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_%s: got code %0d at %0t, required no event", name, got, $time);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        n_fail++;
        $display("FAIL event_%s: got code %0d at %0t, required %0d", name, got, $time, e);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (product)     pop_cmp("product", EV_PROD + int'(product_id));
    if (coin_reject) pop_cmp("reject", EV_REJ);
    if (change)      pop_cmp("change", EV_CHG);
  end

  task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] s,
                     input logic cn, input logic rs);
    @(negedge clk);
    coin = c; sel_valid = sv; sel = s; cancel = cn; restock = rs;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(COIN_NONE, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic push_chg(input int n);
    repeat (n) exp_q.push_back(EV_CHG);
  endtask

  // Insert 1+2 units and buy item 0 (price 3): no change expected.
  task automatic buy0();
    cyc(COIN_1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(COIN_2, 1'b0, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(EV_PROD + 0);
    cyc(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(3);
  endtask

  initial begin
    rst = 1'b0; coin = COIN_NONE; sel = 2'd0; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sold_out", 32'(sold_out), 32'd0);
    rst = 1'b1;

    // 1: reset in the middle of a 5-unit refund cuts it after 2 pulses
    cyc(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    push_chg(2);
    cyc(COIN_NONE, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(2);
    #2 rst = 1'b0;
    #1;
    check("t1_change_in_rst", 32'(change), 32'd0);
    check("t1_credit_in_rst", 32'(credit), 32'd0);
    check("t1_busy_in_rst", 32'(busy), 32'd0);
    check("t1_product_in_rst", 32'(product), 32'd0);
    check("t1_id_in_rst", 32'(product_id), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(4);
    check("t1_credit_after", 32'(credit), 32'd0);
    check("t1_sold_out_after", 32'(sold_out), 32'd0);

    // 2: 1+2 units, buy item 0 -> product id 0 one cycle later, no change
    cyc(COIN_1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(COIN_2, 1'b0, 2'd0, 1'b0, 1'b0);
    check("t2_credit3", 32'(credit), 32'd1);   // second coin not yet clocked
    exp_q.push_back(EV_PROD + 0);
    cyc(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    check("t2_credit_before_vend", 32'(credit), 32'd3);
    idle(1);
    check("t2_product_latency", 32'(product), 32'd1);
    check("t2_busy_vend", 32'(busy), 32'd1);
    idle(2);
    check("t2_credit_end", 32'(credit), 32'd0);
    check("t2_busy_end", 32'(busy), 32'd0);

    // 3: 5 units, buy item 1 (price 2), coin during VEND rejected -> 3 change pulses
    cyc(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(EV_PROD + 1);
    cyc(COIN_NONE, 1'b1, 2'd1, 1'b0, 1'b0);
    exp_q.push_back(EV_REJ);
    push_chg(3);
    cyc(COIN_1, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(2);
    check("t3_busy_change", 32'(busy), 32'd1);
    idle(4);
    check("t3_credit_end", 32'(credit), 32'd0);
    check("t3_busy_end", 32'(busy), 32'd0);

    // 4: credit 2, item 2 (price 4) ignored, then cancel refunds 2
    cyc(COIN_1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(COIN_1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(COIN_NONE, 1'b1, 2'd2, 1'b0, 1'b0);
    idle(2);
    check("t4_credit_kept", 32'(credit), 32'd2);
    check("t4_not_busy", 32'(busy), 32'd0);
    push_chg(2);
    cyc(COIN_NONE, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(4);
    check("t4_credit_end", 32'(credit), 32'd0);

    // 5: exhaust item 0 (4 left after test 2), blocked buy, restock, buy again
    repeat (4) buy0();
    check("t5_sold_out", 32'(sold_out), 32'h1);
    cyc(COIN_2, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(COIN_1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(2);
    check("t5_blocked_credit", 32'(credit), 32'd3);
    check("t5_blocked_busy", 32'(busy), 32'd0);
    cyc(COIN_NONE, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(1);
    check("t5_restocked", 32'(sold_out), 32'h0);
    exp_q.push_back(EV_PROD + 0);
    cyc(COIN_NONE, 1'b1, 2'd0, 1'b0, 1'b0);
    idle(3);
    check("t5_credit_end", 32'(credit), 32'd0);
    check("t5_sold_out_end", 32'(sold_out), 32'h0);

    // 6: 5+5+5 fills credit, 4th coin rejected; cancel+coin rejects coin and refunds 15
    repeat (3) cyc(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(EV_REJ);
    cyc(COIN_5, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(2);
    check("t6_credit_max", 32'(credit), 32'd15);
    check("t6_reject_one_cycle", 32'(coin_reject), 32'd0);
    exp_q.push_back(EV_REJ);
    push_chg(15);
    cyc(COIN_1, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(18);
    check("t6_credit_end", 32'(credit), 32'd0);
    check("t6_busy_end", 32'(busy), 32'd0);

    check("missing_events", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
